// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous word RAM between the core's
//            instruction-fetch port and its data (load/store) port. Accesses
//            are serialised through a small FSM with a fixed RAM read latency.
//            The data port has priority, and a starvation counter forces a
//            fetch grant after MAX_DWIN consecutive data grants while fetch
//            is waiting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W    word-address width driven to the RAM (byte addr [ADDR_W+1:2])
//   LAT       RAM read latency, mem_en to valid mem_rdata_i (1..7)
//   MAX_DWIN  data grants allowed while fetch waits before fetch is forced
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_req_i/if_addr_i         fetch request and byte address
//   if_rdata_o/if_ready_o      fetched word and one-cycle completion pulse
//   d_req_i/d_we_i             data request, 1 = store / 0 = load
//   d_addr_i/d_wdata_i         data byte address and store data
//   d_rdata_o/d_ready_o        load data and one-cycle completion pulse
//   mem_en_o/mem_we_o          RAM access strobe and write enable
//   mem_addr_o/mem_wdata_o     RAM word address and write data
//   mem_rdata_i                RAM read data, valid LAT cycles after mem_en_o
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int LAT      = 2,
  parameter int MAX_DWIN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int              CNT_W        = (MAX_DWIN < 1) ? 1 : $clog2(MAX_DWIN + 1);
  localparam logic [CNT_W-1:0] MAX_DWIN_CNT = CNT_W'(MAX_DWIN);
  localparam logic [2:0]      LAT_CNT      = 3'(LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               gnt_data_q, gnt_data_d;   // 1: access in flight belongs to data port
  logic               store_q, store_d;         // in-flight data access is a store
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;

  logic               w_starved;
  logic               w_grant_d;
  logic               w_grant_i;
  logic               w_unused_addr;

  // Only [ADDR_W+1:2] of each byte address reaches the RAM.
  assign w_unused_addr = ^{if_addr_i, d_addr_i};

  // Arbitration happens only in IDLE; a starved fetch pre-empts data.
  assign w_starved = (starve_q == MAX_DWIN_CNT) && if_req_i;
  assign w_grant_d = (state_q == IDLE) && d_req_i && !w_starved;
  assign w_grant_i = (state_q == IDLE) && if_req_i && !w_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= 3'd0;
      starve_q   <= '0;
      gnt_data_q <= 1'b0;
      store_q    <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      starve_q   <= starve_d;
      gnt_data_q <= gnt_data_d;
      store_q    <= store_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    gnt_data_d  = gnt_data_q;
    store_d     = store_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;

    case (state_q)
      IDLE: begin
        if (w_grant_d || w_grant_i) begin
          mem_en_o    = 1'b1;
          mem_we_o    = w_grant_d && d_we_i;
          mem_addr_o  = w_grant_d ? d_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
          mem_wdata_o = d_wdata_i;
          lat_cnt_d   = LAT_CNT;
          gnt_data_d  = w_grant_d;
          store_d     = w_grant_d && d_we_i;
          state_d     = w_grant_d ? WAIT_D : WAIT_I;
        end
      end
      WAIT_I, WAIT_D: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        // lat_cnt == 1 marks the cycle in which mem_rdata_i is valid.
        if (lat_cnt_q == 3'd1) begin
          state_d = DONE;
          if (state_q == WAIT_I) begin
            if_rdata_d = mem_rdata_i;
          end else if (!store_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Starvation counter: counts data grants that overtake a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || w_grant_i) begin
      starve_d = '0;
    end else if (w_grant_d && (starve_q != MAX_DWIN_CNT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign if_ready_o = (state_q == DONE) && !gnt_data_q;
  assign d_ready_o  = (state_q == DONE) &&  gnt_data_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;

endmodule
`default_nettype wire
